// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache's view; master is the datapath/memory side.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hitcount;
  logic [31:0] misscount;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hitcount, misscount
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hitcount, misscount
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state
// IDLE/MISS fill FSM, combinational hit path and hit/miss counters.
module icache #(
  parameter int NSETS = 16
) (
  input logic    CLK,
  input logic    RST,
  icache_if.slave bus
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, MISS} state_t;

  state_t            state_reg, state_next;
  logic [NSETS-1:0]  valid_reg;
  logic [TW-1:0]     tag_mem  [NSETS];
  logic [31:0]       data_mem [NSETS];
  logic [TW-1:0]     miss_tag_reg;
  logic [IW-1:0]     miss_idx_reg;
  logic [31:0]       hitcount_reg, misscount_reg;

  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_idx;
  logic              hit, miss_start, fill;
  logic [1:0]        unused_offset;

  assign req_tag       = bus.imemaddr[31:IW+2];
  assign req_idx       = bus.imemaddr[IW+1:2];
  assign unused_offset = bus.imemaddr[1:0];

  always_comb begin
    state_next = state_reg;
    hit        = 1'b0;
    miss_start = 1'b0;
    fill       = 1'b0;
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;
    case (state_reg)
      IDLE: begin
        hit        = bus.imemREN & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
        miss_start = bus.imemREN & ~hit;
        if (miss_start) state_next = MISS;
      end
      MISS: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_tag_reg, miss_idx_reg, 2'b00};
        if (!bus.iwait) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset masks every side effect, including a fill completing this cycle.
    if (RST) begin
      hit        = 1'b0;
      miss_start = 1'b0;
      fill       = 1'b0;
      bus.iREN   = 1'b0;
      state_next = IDLE;
    end
  end

  assign bus.ihit      = hit;
  assign bus.imemload  = data_mem[req_idx];
  assign bus.hitcount  = hitcount_reg;
  assign bus.misscount = misscount_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      miss_tag_reg  <= '0;
      miss_idx_reg  <= '0;
      hitcount_reg  <= '0;
      misscount_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (hit) hitcount_reg <= hitcount_reg + 32'd1;
      if (miss_start) begin
        miss_tag_reg  <= req_tag;
        miss_idx_reg  <= req_idx;
        misscount_reg <= misscount_reg + 32'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NSETS; gi++) begin : g_valid
      always_ff @(posedge CLK) begin
        if (RST)
          valid_reg[gi] <= 1'b0;
        else if (fill && (miss_idx_reg == IW'(gi)))
          valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Tag/data storage carries no reset; valid bits alone qualify contents.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[miss_idx_reg]  <= miss_tag_reg;
      data_mem[miss_idx_reg] <= bus.iload;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed and randomized checks of icache against a frame-table model
// that tracks one outstanding miss address.
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  icache_if bus();

  icache #(.NSETS(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_pend;
  logic [29:0] m_paddr;
  logic [31:0] m_hits;
  logic [31:0] m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model.
  task automatic cyc(input logic r, input logic ren, input logic [31:0] a,
                     input logic w, input logic [31:0] ld);
    int  idx;
    bit  e_hit;
    @(negedge clk);
    rst          = r;
    bus.imemREN  = ren;
    bus.imemaddr = a;
    bus.iwait    = w;
    bus.iload    = ld;
    #1;
    idx   = int'(a[5:2]);
    e_hit = !r && !m_pend && ren && m_valid[idx] && (m_tag[idx] == a[31:6]);
    $display("cyc r=%0d ren=%0d a=%h w=%0d ld=%h | ihit=%0d iREN=%0d iaddr=%h hc=%0d mc=%0d",
             r, ren, a, w, ld, bus.ihit, bus.iREN, bus.iaddr, bus.hitcount, bus.misscount);
    chk("ihit", {31'd0, bus.ihit}, {31'd0, e_hit});
    chk("iREN", {31'd0, bus.iREN}, {31'd0, (!r && m_pend)});
    if (!r) begin
      chk("iaddr", bus.iaddr, m_pend ? {m_paddr, 2'b00} : 32'd0);
      chk("hitcount", bus.hitcount, m_hits);
      chk("misscount", bus.misscount, m_miss);
    end
    if (e_hit) chk("imemload", bus.imemload, m_data[idx]);
    if (r) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_pend = 1'b0;
      m_hits = '0;
      m_miss = '0;
    end else if (!m_pend) begin
      if (e_hit) m_hits = m_hits + 32'd1;
      else if (ren) begin
        m_miss  = m_miss + 32'd1;
        m_pend  = 1'b1;
        m_paddr = a[31:2];
      end
    end else if (!w) begin
      m_valid[int'(m_paddr[3:0])] = 1'b1;
      m_tag[int'(m_paddr[3:0])]   = m_paddr[29:4];
      m_data[int'(m_paddr[3:0])]  = ld;
      m_pend = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          ren_cnt;
    rst = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;
    m_pend = 1'b0; m_paddr = '0; m_hits = '0; m_miss = '0;
    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0; end

    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("reset_hitcount", bus.hitcount, 32'd0);
    chk("reset_misscount", bus.misscount, 32'd0);

    // Cold miss: three wait cycles then data.
    ren_cnt = 0;
    cyc(0, 1, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h0, 1, 32'hDEADBEEF);
      if (bus.iREN) ren_cnt++;
    end
    cyc(0, 1, 32'h0, 0, 32'h8C010004);
    if (bus.iREN) ren_cnt++;
    chk("cold_iren_cycles", ren_cnt, 4);
    cyc(0, 1, 32'h2, 1, 0);
    chk("cold_hit", {31'd0, bus.ihit}, 32'd1);
    chk("cold_data", bus.imemload, 32'h8C010004);
    chk("cold_misscount", bus.misscount, 32'd1);
    cyc(0, 1, 32'h2, 1, 0);
    cyc(0, 1, 32'h2, 1, 0);
    chk("held_hitcount", bus.hitcount, 32'd2);

    // Conflict on index 0.
    cyc(0, 1, 32'h40, 1, 0);
    cyc(0, 1, 32'h40, 0, 32'h11112222);
    cyc(0, 1, 32'h40, 1, 0);
    chk("conflict_hit", {31'd0, bus.ihit}, 32'd1);
    cyc(0, 1, 32'h0, 1, 0);
    chk("conflict_remiss", {31'd0, bus.ihit}, 32'd0);
    cyc(0, 1, 32'h0, 0, 32'h8C010004);
    chk("conflict_misscount", bus.misscount, 32'd3);

    // Address change mid-miss.
    cyc(0, 1, 32'h4, 1, 0);
    cyc(0, 1, 32'h8, 1, 0);
    chk("midmiss_iaddr", bus.iaddr, 32'h4);
    cyc(0, 0, 32'h8, 0, 32'hCAFE0001);
    cyc(0, 1, 32'h8, 1, 0);
    chk("midmiss_other_miss", {31'd0, bus.ihit}, 32'd0);
    cyc(0, 1, 32'h8, 0, 32'hCAFE0002);
    cyc(0, 1, 32'h4, 1, 0);
    chk("midmiss_filled", bus.imemload, 32'hCAFE0001);

    // Reset during a miss abandons the fill.
    cyc(0, 1, 32'h10, 1, 0);
    cyc(1, 1, 32'h10, 0, 32'h55555555);
    chk("rst_iren", {31'd0, bus.iREN}, 32'd0);
    cyc(0, 1, 32'h10, 1, 0);
    chk("rst_remiss", {31'd0, bus.ihit}, 32'd0);
    chk("rst_counters", bus.hitcount | bus.misscount, 32'd0);
    cyc(0, 0, 32'h10, 0, 32'h66666666);

    // Randomized traffic over a small tag pool so hits and conflicts recur.
    for (int i = 0; i < 400; i++) begin
      a = {($urandom_range(0, 7) == 0) ? 24'h800000 : 24'h0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), a,
          $urandom_range(0, 1) == 1, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
